// File: rtl/multi_queue_fifo.sv
// multi_queue_fifo: FIFOS linked-list queues sharing one DEPTH-entry RAM through a free pool,
// with per-queue counts, registered pop data, almost-full threshold and sticky error flags.
module multi_queue_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int FIFOS      = 8,
    parameter int LOG2_DEPTH = $clog2(DEPTH),
    parameter int LOG2_FIFOS = $clog2(FIFOS),
    parameter int AF_THRESH  = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_push,
    input  logic [LOG2_FIFOS-1:0]           i_push_fifo,
    input  logic [WIDTH-1:0]                i_d,
    input  logic                            i_pop,
    input  logic [LOG2_FIFOS-1:0]           i_pop_fifo,
    output logic [WIDTH-1:0]                o_q,
    output logic                            o_q_valid,
    output logic                            o_ready,
    output logic [FIFOS-1:0]                o_empty,
    output logic                            o_full,
    output logic                            o_almost_full,
    output logic [LOG2_DEPTH:0]             o_free_count,
    output logic [FIFOS*(LOG2_DEPTH+1)-1:0] o_count,
    output logic                            o_overflow,
    output logic                            o_underflow
);
    localparam int CW = LOG2_DEPTH + 1;
    localparam logic [LOG2_DEPTH-1:0] P_ONE = 1;
    localparam logic [CW-1:0] C_ONE = 1;

    typedef enum logic [1:0] {INIT_Q, INIT_L, RUN} state_t;

    state_t                r_state, w_state_n;
    logic [LOG2_DEPTH-1:0] r_init_cnt;
    logic [WIDTH-1:0]      r_data [DEPTH];
    logic [LOG2_DEPTH-1:0] r_next [DEPTH];
    logic [LOG2_DEPTH-1:0] r_head [FIFOS];
    logic [LOG2_DEPTH-1:0] r_tail [FIFOS];
    logic [LOG2_DEPTH-1:0] r_free_head;
    logic [CW-1:0]         r_free;
    logic [CW-1:0]         r_count [FIFOS];
    logic [WIDTH-1:0]      r_q;
    logic                  r_q_valid, r_ovf, r_udf;
    logic                  w_push_ok, w_pop_ok;
    logic [LOG2_DEPTH-1:0] w_pop_node, w_push_node, w_tail;

    // The init counter runs 0..DEPTH-1 once: queue sentinels first, then free-list links.
    always_comb begin
        w_state_n   = (r_state == INIT_Q && int'(r_init_cnt) == FIFOS - 1) ? INIT_L :
                      (r_state == INIT_L && int'(r_init_cnt) == DEPTH - 1) ? RUN : r_state;
        w_pop_ok    = o_ready && i_pop && !o_empty[i_pop_fifo];
        w_push_ok   = o_ready && i_push && (r_free != '0 || w_pop_ok);
        w_pop_node  = r_head[i_pop_fifo];
        w_push_node = w_pop_ok ? w_pop_node : r_free_head;
        w_tail      = r_tail[i_push_fifo];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= INIT_Q;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_n;
            if (r_state != RUN) r_init_cnt <= r_init_cnt + P_ONE;
        end
    end

    // A popped node is recycled straight into the pushing queue when both happen together.
    always_ff @(posedge i_clk) begin
        if (i_rst && r_state == INIT_Q) begin
            r_head[r_init_cnt[LOG2_FIFOS-1:0]] <= r_init_cnt;
            r_tail[r_init_cnt[LOG2_FIFOS-1:0]] <= r_init_cnt;
        end
        if (i_rst && r_state == INIT_L) r_next[r_init_cnt] <= r_init_cnt + P_ONE;
        if (w_push_ok) begin
            r_data[w_tail]      <= i_d;
            r_next[w_tail]      <= w_push_node;
            r_tail[i_push_fifo] <= w_push_node;
        end else if (w_pop_ok) begin
            r_next[w_pop_node] <= r_free_head;
        end
        if (w_pop_ok) r_head[i_pop_fifo] <= r_next[w_pop_node];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_free_head <= LOG2_DEPTH'(FIFOS);
            r_free      <= CW'(DEPTH - FIFOS);
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            for (int i = 0; i < FIFOS; i++) r_count[i] <= '0;
        end else begin
            r_q_valid <= w_pop_ok;
            if (w_pop_ok) r_q <= r_data[w_pop_node];
            if (i_push && !w_push_ok) r_ovf <= 1'b1;
            if (i_pop && !w_pop_ok) r_udf <= 1'b1;
            if (w_push_ok && !w_pop_ok) begin
                r_free_head <= r_next[r_free_head];
                r_free      <= r_free - C_ONE;
            end else if (w_pop_ok && !w_push_ok) begin
                r_free_head <= w_pop_node;
                r_free      <= r_free + C_ONE;
            end
            for (int i = 0; i < FIFOS; i++)
                r_count[i] <= r_count[i] + ((w_push_ok && int'(i_push_fifo) == i) ? C_ONE : '0)
                                         - ((w_pop_ok && int'(i_pop_fifo) == i) ? C_ONE : '0);
        end
    end

    for (genvar g = 0; g < FIFOS; g++) begin : g_out
        assign o_empty[g]           = r_count[g] == '0;
        assign o_count[g*CW +: CW] = r_count[g];
    end

    assign o_ready       = r_state == RUN;
    assign o_q           = r_q;
    assign o_q_valid     = r_q_valid;
    assign o_full        = r_free == '0;
    assign o_almost_full = int'(r_free) < AF_THRESH;
    assign o_free_count  = r_free;
    assign o_overflow    = r_ovf;
    assign o_underflow   = r_udf;
endmodule

// File: tb/tb_multi_queue_fifo.sv
// tb_multi_queue_fifo: scoreboard bench for multi_queue_fifo with DEPTH=8, FIFOS=2.
module tb_multi_queue_fifo;
    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_push = 1'b0, i_pop = 1'b0;
    logic [0:0] i_push_fifo = '0, i_pop_fifo = '0;
    logic [7:0] i_d = '0;
    logic [7:0] o_q;
    logic       o_q_valid, o_ready, o_full, o_almost_full, o_overflow, o_underflow;
    logic [1:0] o_empty;
    logic [3:0] o_free_count;
    logic [7:0] o_count;

    logic [7:0] mq [2][$];
    logic [7:0] exp_q [$];
    logic [7:0] m_last;
    logic       m_ovf, m_udf, m_rdy;
    int         n_chk = 0, n_err = 0;

    multi_queue_fifo #(.WIDTH(8), .DEPTH(8), .FIFOS(2), .AF_THRESH(2)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_push(i_push), .i_push_fifo(i_push_fifo), .i_d(i_d),
        .i_pop(i_pop), .i_pop_fifo(i_pop_fifo), .o_q(o_q), .o_q_valid(o_q_valid),
        .o_ready(o_ready), .o_empty(o_empty), .o_full(o_full), .o_almost_full(o_almost_full),
        .o_free_count(o_free_count), .o_count(o_count), .o_overflow(o_overflow),
        .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_state();
        int f;
        f = 6 - mq[0].size() - mq[1].size();
        check("free_count", 32'(o_free_count), f);
        check("count0", 32'(o_count[3:0]), mq[0].size());
        check("count1", 32'(o_count[7:4]), mq[1].size());
        check("empty", 32'(o_empty), {30'd0, mq[1].size() == 0, mq[0].size() == 0});
        check("full", 32'(o_full), 32'(f == 0));
        check("almost_full", 32'(o_almost_full), 32'(f < 2));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("underflow", 32'(o_underflow), 32'(m_udf));
        check("ready", 32'(o_ready), 32'(m_rdy));
    endtask

    // One clock of stimulus; the model decides acceptance, the DUT output is compared after the edge.
    task automatic op(input logic pu, input int pf, input logic [7:0] dd, input logic po, input int pof);
        logic pop_ok, push_ok;
        int   f;
        f       = 6 - mq[0].size() - mq[1].size();
        pop_ok  = po && mq[pof].size() != 0;
        push_ok = pu && (f != 0 || pop_ok);
        if (pop_ok) begin
            m_last = mq[pof].pop_front();
            exp_q.push_back(m_last);
        end
        if (push_ok) mq[pf].push_back(dd);
        if (pu && !push_ok) m_ovf = 1'b1;
        if (po && !pop_ok) m_udf = 1'b1;
        i_push = pu; i_push_fifo = 1'(pf); i_d = dd; i_pop = po; i_pop_fifo = 1'(pof);
        @(posedge clk); #1;
        i_push = 1'b0; i_pop = 1'b0;
        check("q_valid", 32'(o_q_valid), 32'(pop_ok));
        if (o_q_valid) begin
            if (exp_q.size() != 0) check("q", 32'(o_q), 32'(exp_q.pop_front()));
            else check("q_unexpected", 32'(o_q_valid), 0);
        end else begin
            check("q_hold", 32'(o_q), 32'(m_last));
        end
        chk_state();
    endtask

    task automatic do_reset(input int n, input logic poke);
        i_rst = 1'b0; i_push = 1'b0; i_pop = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        mq[0].delete(); mq[1].delete(); exp_q.delete();
        m_last = '0; m_ovf = 1'b0; m_udf = 1'b0; m_rdy = 1'b0;
        check("rst_q_valid", 32'(o_q_valid), 0);
        check("rst_q", 32'(o_q), 0);
        chk_state();
        i_rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            i_push = poke && e == 3; i_push_fifo = 1'b0; i_d = 8'h77;
            if (poke && e == 3) m_ovf = 1'b1;
            @(posedge clk); #1;
            i_push = 1'b0;
            check($sformatf("ready_edge%0d", e), 32'(o_ready), 32'(e == 8));
        end
        m_rdy = 1'b1;
        chk_state();
    endtask

    initial begin
        do_reset(3, 1'b0);
        for (int i = 0; i < 7; i++) op(1'b1, 1, 8'(8'h10 + i), 1'b0, 0);
        for (int i = 0; i < 6; i++) op(1'b0, 0, 8'h00, 1'b1, 1);
        op(1'b1, 0, 8'hA0, 1'b0, 0);
        op(1'b1, 1, 8'hB0, 1'b0, 0);
        op(1'b1, 0, 8'hA1, 1'b0, 0);
        op(1'b1, 1, 8'hB1, 1'b0, 0);
        op(1'b0, 0, 8'h00, 1'b1, 0);
        op(1'b0, 0, 8'h00, 1'b1, 1);
        op(1'b0, 0, 8'h00, 1'b1, 0);
        op(1'b0, 0, 8'h00, 1'b1, 1);
        for (int i = 0; i < 6; i++) op(1'b1, 0, 8'(8'h20 + i), 1'b0, 0);
        op(1'b1, 1, 8'h99, 1'b1, 0);
        op(1'b1, 0, 8'h5A, 1'b1, 0);
        for (int i = 0; i < 5; i++) op(1'b0, 0, 8'h00, 1'b1, 0);
        op(1'b0, 0, 8'h00, 1'b1, 1);
        op(1'b1, 0, 8'h42, 1'b1, 0);
        op(1'b0, 0, 8'h00, 1'b1, 0);
        for (int i = 0; i < 80; i++)
            op(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        while (mq[0].size() + mq[1].size() < 4) op(1'b1, 0, 8'hE0, 1'b0, 0);
        do_reset(1, 1'b1);
        op(1'b0, 0, 8'h00, 1'b1, 0);
        op(1'b0, 0, 8'h00, 1'b1, 1);
        op(1'b1, 1, 8'h3C, 1'b0, 0);
        op(1'b0, 0, 8'h00, 1'b1, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
